// File: rtl/alu_rs_scheduler.sv
// Reservation station and single-issue scheduler for the integer ALU.
// Captures operands from two CDB ports and issues the lowest-index ready entry each cycle.
module alu_rs_scheduler #(
  parameter int unsigned      RS_N     = 8,
  parameter int unsigned      DATA_W   = 32,
  parameter int unsigned      TAG_W    = 5,
  parameter logic [TAG_W-1:0] TAG_FREE = 5'b10000,
  parameter int unsigned      NAME_W   = 5,
  parameter int unsigned      OP_W     = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              dispEn,
  input  logic [OP_W-1:0]   dispOp,
  input  logic [DATA_W-1:0] dispValO,
  input  logic [DATA_W-1:0] dispValT,
  input  logic [TAG_W-1:0]  dispTagO,
  input  logic [TAG_W-1:0]  dispTagT,
  input  logic [TAG_W-1:0]  dispWrtTag,
  input  logic [NAME_W-1:0] dispWrtName,
  input  logic [DATA_W-1:0] dispAddr,
  input  logic              cdbAEn,
  input  logic              cdbBEn,
  input  logic [TAG_W-1:0]  cdbATag,
  input  logic [TAG_W-1:0]  cdbBTag,
  input  logic [DATA_W-1:0] cdbAData,
  input  logic [DATA_W-1:0] cdbBData,
  output logic              rsFull,
  output logic              ALUworkEn,
  output logic [DATA_W-1:0] operandO,
  output logic [DATA_W-1:0] operandT,
  output logic [TAG_W-1:0]  wrtTag,
  output logic [NAME_W-1:0] wrtName,
  output logic [OP_W-1:0]   opCode,
  output logic [DATA_W-1:0] instAddr
);

  localparam int unsigned IDX_W = (RS_N > 1) ? $clog2(RS_N) : 1;
  localparam int unsigned CNT_W = $clog2(RS_N + 1);

  logic              valid   [RS_N];
  logic [OP_W-1:0]   op      [RS_N];
  logic [DATA_W-1:0] val_o   [RS_N];
  logic [DATA_W-1:0] val_t   [RS_N];
  logic [TAG_W-1:0]  tag_o   [RS_N];
  logic [TAG_W-1:0]  tag_t   [RS_N];
  logic [TAG_W-1:0]  wr_tag  [RS_N];
  logic [NAME_W-1:0] wr_name [RS_N];
  logic [DATA_W-1:0] addr    [RS_N];

  logic [CNT_W-1:0]  count;
  logic              sel_found;
  logic [IDX_W-1:0]  sel_idx;
  logic              free_found;
  logic [IDX_W-1:0]  free_idx;
  logic              accept;
  logic              a_live, b_live;
  logic [TAG_W-1:0]  disp_tag_o, disp_tag_t;
  logic [DATA_W-1:0] disp_val_o, disp_val_t;

  assign rsFull = (count == CNT_W'(RS_N));
  assign accept = dispEn && !rsFull;
  assign a_live = cdbAEn && (cdbATag != TAG_FREE);
  assign b_live = cdbBEn && (cdbBTag != TAG_FREE);

  // Selection and slot allocation look only at registered state, so a freshly
  // dispatched or woken entry becomes eligible one cycle later.
  always_comb begin
    sel_found  = 1'b0;
    sel_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int unsigned i = 0; i < RS_N; i++) begin
      if (!sel_found && valid[i] && tag_o[i] == TAG_FREE && tag_t[i] == TAG_FREE) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
      if (!free_found && !valid[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    disp_tag_o = dispTagO;
    disp_val_o = dispValO;
    disp_tag_t = dispTagT;
    disp_val_t = dispValT;
    if (a_live && dispTagO == cdbATag) begin
      disp_tag_o = TAG_FREE;
      disp_val_o = cdbAData;
    end else if (b_live && dispTagO == cdbBTag) begin
      disp_tag_o = TAG_FREE;
      disp_val_o = cdbBData;
    end
    if (a_live && dispTagT == cdbATag) begin
      disp_tag_t = TAG_FREE;
      disp_val_t = cdbAData;
    end else if (b_live && dispTagT == cdbBTag) begin
      disp_tag_t = TAG_FREE;
      disp_val_t = cdbBData;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < RS_N; i++) begin
        valid[i]   <= 1'b0;
        op[i]      <= '0;
        val_o[i]   <= '0;
        val_t[i]   <= '0;
        tag_o[i]   <= TAG_FREE;
        tag_t[i]   <= TAG_FREE;
        wr_tag[i]  <= '0;
        wr_name[i] <= '0;
        addr[i]    <= '0;
      end
      count     <= '0;
      ALUworkEn <= 1'b0;
      operandO  <= '0;
      operandT  <= '0;
      wrtTag    <= TAG_FREE;
      wrtName   <= '0;
      opCode    <= '0;
      instAddr  <= '0;
    end else if (clear) begin
      for (int unsigned i = 0; i < RS_N; i++) valid[i] <= 1'b0;
      count     <= '0;
      ALUworkEn <= 1'b0;
      operandO  <= '0;
      operandT  <= '0;
      wrtTag    <= TAG_FREE;
      wrtName   <= '0;
      opCode    <= '0;
      instAddr  <= '0;
    end else begin
      for (int unsigned i = 0; i < RS_N; i++) begin
        if (valid[i]) begin
          if (a_live && tag_o[i] == cdbATag) begin
            val_o[i] <= cdbAData;
            tag_o[i] <= TAG_FREE;
          end else if (b_live && tag_o[i] == cdbBTag) begin
            val_o[i] <= cdbBData;
            tag_o[i] <= TAG_FREE;
          end
          if (a_live && tag_t[i] == cdbATag) begin
            val_t[i] <= cdbAData;
            tag_t[i] <= TAG_FREE;
          end else if (b_live && tag_t[i] == cdbBTag) begin
            val_t[i] <= cdbBData;
            tag_t[i] <= TAG_FREE;
          end
        end
      end

      if (sel_found) begin
        ALUworkEn       <= 1'b1;
        operandO        <= val_o[sel_idx];
        operandT        <= val_t[sel_idx];
        wrtTag          <= wr_tag[sel_idx];
        wrtName         <= wr_name[sel_idx];
        opCode          <= op[sel_idx];
        instAddr        <= addr[sel_idx];
        valid[sel_idx]  <= 1'b0;
      end else begin
        ALUworkEn <= 1'b0;
      end

      // The free slot is always an invalid entry, so it never collides with
      // the issued entry or with a wakeup target.
      if (accept && free_found) begin
        valid[free_idx]   <= 1'b1;
        op[free_idx]      <= dispOp;
        val_o[free_idx]   <= disp_val_o;
        val_t[free_idx]   <= disp_val_t;
        tag_o[free_idx]   <= disp_tag_o;
        tag_t[free_idx]   <= disp_tag_t;
        wr_tag[free_idx]  <= dispWrtTag;
        wr_name[free_idx] <= dispWrtName;
        addr[free_idx]    <= dispAddr;
      end

      case ({accept, sel_found})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rs_scheduler.sv
// Self-checking bench for alu_rs_scheduler: directed scenarios plus randomized
// traffic compared against an entry-list reference model.
module tb_alu_rs_scheduler;

  localparam logic [4:0] FREE = 5'b10000;

  logic        clk = 1'b0;
  logic        rst, clear, dispEn;
  logic [5:0]  dispOp;
  logic [31:0] dispValO, dispValT, dispAddr;
  logic [4:0]  dispTagO, dispTagT, dispWrtTag, dispWrtName;
  logic        cdbAEn, cdbBEn;
  logic [4:0]  cdbATag, cdbBTag;
  logic [31:0] cdbAData, cdbBData;
  logic        rsFull, ALUworkEn;
  logic [31:0] operandO, operandT, instAddr;
  logic [4:0]  wrtTag, wrtName;
  logic [5:0]  opCode;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_rs_scheduler #(.RS_N(8), .DATA_W(32), .TAG_W(5), .TAG_FREE(5'b10000),
                     .NAME_W(5), .OP_W(6)) dut (
    .clk(clk), .rst(rst), .clear(clear), .dispEn(dispEn), .dispOp(dispOp),
    .dispValO(dispValO), .dispValT(dispValT), .dispTagO(dispTagO), .dispTagT(dispTagT),
    .dispWrtTag(dispWrtTag), .dispWrtName(dispWrtName), .dispAddr(dispAddr),
    .cdbAEn(cdbAEn), .cdbBEn(cdbBEn), .cdbATag(cdbATag), .cdbBTag(cdbBTag),
    .cdbAData(cdbAData), .cdbBData(cdbBData), .rsFull(rsFull), .ALUworkEn(ALUworkEn),
    .operandO(operandO), .operandT(operandT), .wrtTag(wrtTag), .wrtName(wrtName),
    .opCode(opCode), .instAddr(instAddr)
  );

  // Reference model: a slot table plus the issue output state.
  typedef struct {
    bit          v;
    logic [5:0]  op;
    logic [31:0] vo, vt, addr;
    logic [4:0]  to, tt, wt, wn;
  } ent_t;

  ent_t        m [8];
  logic        m_en;
  logic [31:0] m_o, m_t, m_addr;
  logic [4:0]  m_wt, m_wn;
  logic [5:0]  m_op;

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < 8; i++) if (m[i].v) n++;
    return n;
  endfunction

  function automatic logic [36:0] grab(input logic [4:0] t, input logic [31:0] v);
    if (cdbAEn && cdbATag != FREE && t == cdbATag) return {FREE, cdbAData};
    if (cdbBEn && cdbBTag != FREE && t == cdbBTag) return {FREE, cdbBData};
    return {t, v};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m[i].v = 0;
    m_en = 0; m_o = 0; m_t = 0; m_addr = 0; m_wt = FREE; m_wn = 0; m_op = 0;
  endtask

  task automatic model_edge();
    ent_t nm [8];
    int sel = -1;
    int fr  = -1;
    if (clear) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 8; i++) begin
      if (sel < 0 && m[i].v && m[i].to == FREE && m[i].tt == FREE) sel = i;
      if (fr < 0 && !m[i].v) fr = i;
    end
    nm = m;
    for (int i = 0; i < 8; i++) if (m[i].v) begin
      {nm[i].to, nm[i].vo} = grab(m[i].to, m[i].vo);
      {nm[i].tt, nm[i].vt} = grab(m[i].tt, m[i].vt);
    end
    if (sel >= 0) begin
      m_en = 1; m_o = m[sel].vo; m_t = m[sel].vt; m_wt = m[sel].wt;
      m_wn = m[sel].wn; m_op = m[sel].op; m_addr = m[sel].addr;
      nm[sel].v = 0;
    end else m_en = 0;
    if (dispEn && m_count() < 8) begin
      nm[fr].v = 1; nm[fr].op = dispOp; nm[fr].wt = dispWrtTag;
      nm[fr].wn = dispWrtName; nm[fr].addr = dispAddr;
      {nm[fr].to, nm[fr].vo} = grab(dispTagO, dispValO);
      {nm[fr].tt, nm[fr].vt} = grab(dispTagT, dispValT);
    end
    m = nm;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    clear = 0; dispEn = 0; dispOp = 0; dispValO = 0; dispValT = 0;
    dispTagO = FREE; dispTagT = FREE; dispWrtTag = 0; dispWrtName = 0; dispAddr = 0;
    cdbAEn = 0; cdbBEn = 0; cdbATag = FREE; cdbBTag = FREE; cdbAData = 0; cdbBData = 0;
  endtask

  task automatic disp(input logic [5:0] op, input logic [31:0] vo, input logic [4:0] to,
                      input logic [31:0] vt, input logic [4:0] tt, input logic [4:0] wt);
    dispEn = 1; dispOp = op; dispValO = vo; dispTagO = to; dispValT = vt; dispTagT = tt;
    dispWrtTag = wt; dispWrtName = wt + 5'd1; dispAddr = 32'h1000 + {27'd0, wt};
  endtask

  task automatic flush_cycle();
    idle(); clear = 1; cyc(); idle();
  endtask

  task automatic test_reset();
    idle(); rst = 1; model_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (ALUworkEn !== 1'b0) begin bad++; $display("FAIL reset_en got=%b exp=0", ALUworkEn); end
    total++; if (rsFull !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", rsFull); end
    total++; if (wrtTag !== FREE) begin bad++; $display("FAIL reset_wrtTag got=%h exp=%h", wrtTag, FREE); end
    total++; if ({operandO, operandT, instAddr} !== 96'd0) begin bad++;
      $display("FAIL reset_data got=%h/%h/%h exp=0", operandO, operandT, instAddr); end
    rst = 0;
  endtask

  task automatic test_single();
    flush_cycle();
    disp(6'h01, 32'd5, FREE, 32'd7, FREE, 5'd3);
    cyc(); idle();
    total++; if (ALUworkEn !== 1'b0) begin bad++; $display("FAIL single_early got=%b exp=0", ALUworkEn); end
    cyc();
    total++; if ({ALUworkEn, operandO, operandT, wrtTag, opCode} !== {1'b1, 32'd5, 32'd7, 5'd3, 6'h01}) begin bad++;
      $display("FAIL single_issue got en=%b o=%0d t=%0d tag=%0d op=%h exp en=1 o=5 t=7 tag=3 op=01",
               ALUworkEn, operandO, operandT, wrtTag, opCode); end
    total++; if ({wrtName, instAddr} !== {5'd4, 32'h1003}) begin bad++;
      $display("FAIL single_meta got name=%0d addr=%h exp name=4 addr=1003", wrtName, instAddr); end
    cyc();
    total++; if (ALUworkEn !== 1'b0 || operandO !== 32'd5) begin bad++;
      $display("FAIL single_pulse got en=%b o=%0d exp en=0 o=5", ALUworkEn, operandO); end
  endtask

  task automatic test_wakeup();
    flush_cycle();
    disp(6'h02, 32'd0, 5'd9, 32'd1, FREE, 5'd4);
    cyc(); idle();
    for (int k = 0; k < 2; k++) begin
      cyc();
      total++; if (ALUworkEn !== 1'b0) begin bad++; $display("FAIL wakeup_wait%0d got=%b exp=0", k, ALUworkEn); end
    end
    cdbBEn = 1; cdbBTag = 5'd9; cdbBData = 32'd20;
    cyc(); idle();
    total++; if (ALUworkEn !== 1'b0) begin bad++; $display("FAIL wakeup_bcast_edge got=%b exp=0", ALUworkEn); end
    cyc();
    total++; if ({ALUworkEn, operandO, operandT, wrtTag} !== {1'b1, 32'd20, 32'd1, 5'd4}) begin bad++;
      $display("FAIL wakeup_issue got en=%b o=%0d t=%0d tag=%0d exp en=1 o=20 t=1 tag=4",
               ALUworkEn, operandO, operandT, wrtTag); end
  endtask

  task automatic test_bypass();
    flush_cycle();
    disp(6'h03, 32'd3, FREE, 32'd0, 5'd4, 5'd6);
    cdbAEn = 1; cdbATag = 5'd4; cdbAData = 32'hDEAD;
    cyc(); idle();
    cyc();
    total++; if ({ALUworkEn, operandO, operandT, wrtTag} !== {1'b1, 32'd3, 32'hDEAD, 5'd6}) begin bad++;
      $display("FAIL bypass_issue got en=%b o=%h t=%h tag=%0d exp en=1 o=3 t=dead tag=6",
               ALUworkEn, operandO, operandT, wrtTag); end
  endtask

  task automatic test_full();
    flush_cycle();
    for (int i = 0; i < 8; i++) begin
      disp(6'h04, 32'd0, 5'd12, 32'(i), FREE, 5'(i));
      cyc();
    end
    total++; if (rsFull !== 1'b1) begin bad++; $display("FAIL full_set got=%b exp=1", rsFull); end
    disp(6'h04, 32'd0, FREE, 32'd0, FREE, 5'd8);
    cyc(); idle();
    total++; if (rsFull !== 1'b1 || ALUworkEn !== 1'b0) begin bad++;
      $display("FAIL full_drop got full=%b en=%b exp full=1 en=0", rsFull, ALUworkEn); end
    cdbAEn = 1; cdbATag = 5'd12; cdbAData = 32'd77;
    cyc(); idle();
    for (int k = 0; k < 8; k++) begin
      cyc();
      total++; if ({ALUworkEn, wrtTag, operandO, operandT} !== {1'b1, 5'(k), 32'd77, 32'(k)}) begin bad++;
        $display("FAIL full_order%0d got en=%b tag=%0d o=%0d t=%0d exp en=1 tag=%0d o=77 t=%0d",
                 k, ALUworkEn, wrtTag, operandO, operandT, k, k); end
      if (k == 0) begin
        total++; if (rsFull !== 1'b0) begin bad++; $display("FAIL full_release got=%b exp=0", rsFull); end
      end
    end
    cyc();
    total++; if (ALUworkEn !== 1'b0) begin bad++; $display("FAIL full_ninth got=%b exp=0", ALUworkEn); end
  endtask

  task automatic test_flush();
    flush_cycle();
    for (int i = 0; i < 4; i++) begin
      disp(6'h05, 32'd0, 5'd13, 32'd0, 5'd14, 5'(i + 20));
      cyc();
    end
    disp(6'h05, 32'd1, FREE, 32'd2, FREE, 5'd30);
    clear = 1;
    cyc(); idle();
    total++; if (ALUworkEn !== 1'b0 || rsFull !== 1'b0 || wrtTag !== FREE) begin bad++;
      $display("FAIL flush_state got en=%b full=%b tag=%h exp en=0 full=0 tag=10", ALUworkEn, rsFull, wrtTag); end
    cdbAEn = 1; cdbATag = 5'd13; cdbBEn = 1; cdbBTag = 5'd14;
    cyc(); idle();
    for (int k = 0; k < 3; k++) begin
      cyc();
      total++; if (ALUworkEn !== 1'b0) begin bad++; $display("FAIL flush_noissue%0d got=%b exp=0", k, ALUworkEn); end
    end
  endtask

  task automatic test_reset_mid();
    flush_cycle();
    disp(6'h06, 32'd0, 5'd14, 32'd0, FREE, 5'd1); cyc();
    disp(6'h06, 32'd0, 5'd14, 32'd0, FREE, 5'd2); cyc();
    disp(6'h06, 32'd8, FREE, 32'd9, FREE, 5'd3); cyc();
    idle(); cyc();
    total++; if (ALUworkEn !== 1'b1) begin bad++; $display("FAIL rstmid_pre got=%b exp=1", ALUworkEn); end
    #2 rst = 1; model_reset();
    #1;
    total++; if ({ALUworkEn, rsFull, wrtTag, operandO} !== {1'b0, 1'b0, FREE, 32'd0}) begin bad++;
      $display("FAIL rstmid_async got en=%b full=%b tag=%h o=%0d exp en=0 full=0 tag=10 o=0",
               ALUworkEn, rsFull, wrtTag, operandO); end
    #1 rst = 0;
    disp(6'h07, 32'd11, FREE, 32'd12, FREE, 5'd6);
    cyc(); idle(); cyc();
    total++; if ({ALUworkEn, operandO, operandT, wrtTag} !== {1'b1, 32'd11, 32'd12, 5'd6}) begin bad++;
      $display("FAIL rstmid_after got en=%b o=%0d t=%0d tag=%0d exp en=1 o=11 t=12 tag=6",
               ALUworkEn, operandO, operandT, wrtTag); end
    cdbAEn = 1; cdbATag = 5'd14;
    cyc(); idle(); cyc();
    total++; if (ALUworkEn !== 1'b0) begin bad++; $display("FAIL rstmid_stale got=%b exp=0", ALUworkEn); end
  endtask

  function automatic logic [4:0] rtag();
    return ($urandom_range(0, 4) == 4) ? FREE : 5'($urandom_range(0, 3));
  endfunction

  task automatic test_random();
    logic [113:0] got, exp;
    flush_cycle();
    for (int n = 0; n < 600; n++) begin
      dispEn = ($urandom_range(0, 9) < 6); dispOp = 6'($urandom);
      dispValO = $urandom; dispValT = $urandom; dispTagO = rtag(); dispTagT = rtag();
      dispWrtTag = 5'($urandom); dispWrtName = 5'($urandom); dispAddr = $urandom;
      cdbAEn = ($urandom_range(0, 9) < 3); cdbATag = rtag(); cdbAData = $urandom;
      cdbBEn = ($urandom_range(0, 9) < 3); cdbBTag = rtag(); cdbBData = $urandom;
      clear = ($urandom_range(0, 99) < 2);
      cyc();
      got = {ALUworkEn, rsFull, opCode, wrtTag, wrtName, operandO, operandT, instAddr};
      exp = {m_en, (m_count() == 8), m_op, m_wt, m_wn, m_o, m_t, m_addr};
      total++; if (got !== exp) begin bad++;
        $display("FAIL random_cycle%0d got=%h exp=%h", n, got, exp); end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_wakeup();
    test_bypass();
    test_full();
    test_flush();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
